// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: MMIO addresses, TSTAT bit positions and decoded-target enum shared by dmem_mmio and mmio_timer
package dmem_mmio_pkg;
  localparam logic [31:0] TCOUNT_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] TCMP_ADDR   = 32'hFFFF_0004;
  localparam logic [31:0] TSTAT_ADDR  = 32'hFFFF_0008;
  localparam logic [31:0] LEDS_ADDR   = 32'hFFFF_000C;
  localparam int TSTAT_FLAG = 0;
  localparam int TSTAT_EN   = 1;
  typedef enum logic [2:0] {TGT_RAM, TGT_TCOUNT, TGT_TCMP, TGT_TSTAT, TGT_LEDS, TGT_NONE} target_t;
endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: programmable timer (count/cmp/flag/en); ports clk, reset, per-register write strobes, wdata, state outputs
module mmio_timer
  import dmem_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        cmp_we,
  input  logic        stat_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] cmp,
  output logic        flag,
  output logic        en
);
  logic match;
  assign match = en && count == cmp;
  // a CPU count write beats wrap/increment; flag set beats a same-cycle clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count <= '0;
      cmp   <= '1;
      flag  <= 1'b0;
      en    <= 1'b0;
    end else begin
      count <= count_we ? wdata : match ? '0 : en ? count + 32'd1 : count;
      cmp   <= cmp_we ? wdata : cmp;
      flag  <= match | (flag & ~(stat_we & wdata[TSTAT_FLAG]));
      en    <= stat_we ? wdata[TSTAT_EN] : en;
    end
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: CPU data-memory responder (RAM, LED register, timer); ports clk, reset, mem_wr/mem_addr/mem_writedata/mem_readdata, leds, timer_irq
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int          LED_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_wr,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_writedata,
  output logic [31:0]          mem_readdata,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 timer_irq
);
  localparam int AW = $clog2(DMEM_WORDS);
  logic [31:0] off, count, cmp, stat;
  logic        flag, en;
  target_t     tgt;
  logic [31:0] ram [DMEM_WORDS];
  // unsigned offset: addresses below the base wrap high and fall outside the RAM window
  assign off = mem_addr - DMEM_BASE;
  always_comb
    tgt = off < 32'(4 * DMEM_WORDS)           ? TGT_RAM    :
          mem_addr[31:2] == TCOUNT_ADDR[31:2] ? TGT_TCOUNT :
          mem_addr[31:2] == TCMP_ADDR[31:2]   ? TGT_TCMP   :
          mem_addr[31:2] == TSTAT_ADDR[31:2]  ? TGT_TSTAT  :
          mem_addr[31:2] == LEDS_ADDR[31:2]   ? TGT_LEDS   : TGT_NONE;
  always_ff @(posedge clk)
    if (mem_wr && tgt == TGT_RAM) ram[off[AW+1:2]] <= mem_writedata;
  always_ff @(posedge clk or posedge reset)
    if (reset) leds <= '0;
    else if (mem_wr && tgt == TGT_LEDS) leds <= mem_writedata[LED_WIDTH-1:0];
  mmio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .count_we (mem_wr && tgt == TGT_TCOUNT),
    .cmp_we   (mem_wr && tgt == TGT_TCMP),
    .stat_we  (mem_wr && tgt == TGT_TSTAT),
    .wdata    (mem_writedata),
    .count    (count),
    .cmp      (cmp),
    .flag     (flag),
    .en       (en)
  );
  always_comb begin
    stat = '0;
    stat[TSTAT_EN] = en;
    stat[TSTAT_FLAG] = flag;
  end
  always_comb
    mem_readdata = tgt == TGT_RAM    ? ram[off[AW+1:2]] :
                   tgt == TGT_TCOUNT ? count            :
                   tgt == TGT_TCMP   ? cmp              :
                   tgt == TGT_TSTAT  ? stat             :
                   tgt == TGT_LEDS   ? 32'(leds)        : '0;
  assign timer_irq = flag & en;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed self-checking bench for dmem_mmio
module tb_dmem_mmio;
  logic        clk, reset, mem_wr, timer_irq;
  logic [31:0] mem_addr, mem_writedata, mem_readdata;
  logic [15:0] leds;
  int checks = 0, failures = 0;
  localparam logic [31:0] TCOUNT = 32'hFFFF_0000, TCMP = 32'hFFFF_0004, TSTAT = 32'hFFFF_0008, LEDS = 32'hFFFF_000C;
  dmem_mmio dut (
    .clk           (clk),
    .reset         (reset),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .leds          (leds),
    .timer_irq     (timer_irq)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    mem_addr = addr;
    #1;
    check(tag, mem_readdata, exp);
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    mem_wr = 1;
    mem_addr = addr;
    mem_writedata = data;
    @(posedge clk);
    #1;
    mem_wr = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 0; mem_wr = 0; mem_addr = 0; mem_writedata = 0;
    #2 reset = 1;
    rd("reset_tcmp", TCMP, 32'hFFFF_FFFF);
    check("reset_leds", {16'b0, leds}, 0);
    check("reset_irq", {31'b0, timer_irq}, 0);
    rd("reset_tcount", TCOUNT, 0);
    @(negedge clk) reset = 0;
    tick();
    wr(32'h1001_0000, 32'hDEAD_BEEF);
    wr(32'h1001_00FC, 32'h1234_5678);
    wr(32'h1001_0100, 32'h5555_5555);
    rd("ram_w0", 32'h1001_0000, 32'hDEAD_BEEF);
    rd("ram_w63", 32'h1001_00FC, 32'h1234_5678);
    rd("ram_past_end", 32'h1001_0100, 0);
    rd("ram_below_base", 32'h1000_FFFC, 0);
    wr(LEDS, 32'hABCD_1234);
    check("leds_out", {16'b0, leds}, 32'h0000_1234);
    rd("leds_read", LEDS, 32'h0000_1234);
    wr(32'h0000_0040, 32'h0F0F_0F0F);
    rd("unmapped_read", 32'h0000_0040, 0);
    check("unmapped_leds", {16'b0, leds}, 32'h0000_1234);
    rd("unmapped_ram", 32'h1001_0000, 32'hDEAD_BEEF);
    rd("unmapped_tcmp", TCMP, 32'hFFFF_FFFF);
    wr(TCMP, 4);
    wr(TSTAT, 2);
    rd("en_set", TSTAT, 2);
    repeat (4) tick();
    check("period_pre", {31'b0, timer_irq}, 0);
    rd("period_count4", TCOUNT, 4);
    tick();
    check("period_irq", {31'b0, timer_irq}, 1);
    rd("period_wrap", TCOUNT, 0);
    wr(TSTAT, 3);
    rd("clear_stat", TSTAT, 2);
    check("clear_irq", {31'b0, timer_irq}, 0);
    repeat (3) tick();
    check("reperiod_pre", {31'b0, timer_irq}, 0);
    tick();
    check("reperiod_irq", {31'b0, timer_irq}, 1);
    wr(TCMP, 3);
    wr(TSTAT, 3);
    rd("coll_cleared", TSTAT, 2);
    rd("coll_count2", TCOUNT, 2);
    tick();
    rd("coll_count3", TCOUNT, 3);
    wr(TSTAT, 3);
    rd("coll_flag_kept", TSTAT, 3);
    rd("coll_wrap", TCOUNT, 0);
    wr(TCMP, 32'hFFFF_FFFF);
    wr(TSTAT, 3);
    wr(TCOUNT, 32'hFFFF_FFFE);
    rd("ovr_load", TCOUNT, 32'hFFFF_FFFE);
    check("ovr_irq0", {31'b0, timer_irq}, 0);
    tick();
    rd("ovr_max", TCOUNT, 32'hFFFF_FFFF);
    check("ovr_irq1", {31'b0, timer_irq}, 0);
    tick();
    rd("ovr_wrap", TCOUNT, 0);
    check("ovr_match", {31'b0, timer_irq}, 1);
    wr(TCOUNT, 7);
    rd("load7", TCOUNT, 7);
    tick();
    rd("inc8", TCOUNT, 8);
    reset = 1;
    rd("async_count", TCOUNT, 0);
    rd("async_stat", TSTAT, 0);
    check("async_irq", {31'b0, timer_irq}, 0);
    check("async_leds", {16'b0, leds}, 0);
    reset = 0;
    repeat (2) tick();
    rd("post_reset_hold", TCOUNT, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
